// File: rtl/mac_rx_arbiter_pkg.sv
// mac_rx_arbiter_pkg: shared bounds, arbiter state encoding and packet framing rule
// Contents: NUM_QUEUES bounds, arb_state_e (ARB_IDLE/ARB_XFER), is_body() framing helper.
package mac_rx_arbiter_pkg;
    localparam int NUM_QUEUES_MIN = 2;
    localparam int NUM_QUEUES_MAX = 8;
    localparam int CTRL_WIDTH_MAX = 64;

    typedef enum logic {
        ARB_IDLE,
        ARB_XFER
    } arb_state_e;

    // A word whose ctrl is all zero is a packet body word; anything else is header or EOP.
    function automatic logic is_body(input logic [CTRL_WIDTH_MAX-1:0] ctrl);
        return ctrl == '0;
    endfunction
endpackage

// File: rtl/mac_rx_arbiter_if.sv
// mac_rx_arbiter_if: MAC-side input bundle and merged output bus of the receive arbiter
// Signals: in_data/in_ctrl/in_wr/in_rdy per queue, out_data/out_ctrl/out_wr/out_rdy, overflow.
// master = upstream/downstream environment, slave = arbiter.
interface mac_rx_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_QUEUES = 4
);
    logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data;
    logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl;
    logic [NUM_QUEUES-1:0]            in_wr;
    logic [NUM_QUEUES-1:0]            in_rdy;
    logic [DATA_WIDTH-1:0]            out_data;
    logic [CTRL_WIDTH-1:0]            out_ctrl;
    logic                             out_wr;
    logic                             out_rdy;
    logic [NUM_QUEUES-1:0]            overflow;

    modport master (
        output in_data, in_ctrl, in_wr, out_rdy,
        input  in_rdy, out_data, out_ctrl, out_wr, overflow
    );

    modport slave (
        input  in_data, in_ctrl, in_wr, out_rdy,
        output in_rdy, out_data, out_ctrl, out_wr, overflow
    );
endinterface

// File: rtl/mac_rx_arbiter_arb_in_fifo.sv
// arb_in_fifo: single-clock first-word-fall-through FIFO feeding one arbiter input
// Ports: clk, reset (sync, active-low), din_i/wr_en_i push side, rd_en_i pop,
//        dout_o head word, count_o/empty_o/full_o/prog_full_o status (prog_full = count > DEPTH-3).
module arb_in_fifo #(
    parameter int WIDTH      = 72,
    parameter int DEPTH_BITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      din_i,
    input  logic                  wr_en_i,
    input  logic                  rd_en_i,
    output logic [WIDTH-1:0]      dout_o,
    output logic [DEPTH_BITS:0]   count_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  prog_full_o
);
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam int CW    = DEPTH_BITS + 1;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  push, pop;

    assign empty_o     = count_q == '0;
    assign full_o      = count_q == CW'(DEPTH);
    assign prog_full_o = count_q > CW'(DEPTH - 3);
    assign count_o     = count_q;
    assign dout_o      = mem_q[rd_ptr_q];
    // A pop in the same cycle frees a slot, so a full FIFO still takes the write.
    assign push = wr_en_i && (!full_o || rd_en_i);
    assign pop  = rd_en_i && !empty_o;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + DEPTH_BITS'(push);
            rd_ptr_q <= rd_ptr_q + DEPTH_BITS'(pop);
            count_q  <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) if (push) mem_q[wr_ptr_q] <= din_i;
endmodule

// File: rtl/mac_rx_arbiter.sv
// mac_rx_arbiter: merges per-MAC receive streams into one datapath, packet-granular round robin
// Ports: clk, reset (sync, active-low), bus (mac_rx_arbiter_if.slave: per-queue inputs with
//        in_rdy, registered merged output with out_rdy backpressure, sticky overflow flags).
module mac_rx_arbiter
    import mac_rx_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int NUM_QUEUES      = 4,
    parameter int FIFO_DEPTH_BITS = 3
) (
    input logic             clk,
    input logic             reset,
    mac_rx_arbiter_if.slave bus
);
    localparam int QW = $clog2(NUM_QUEUES);
    localparam int WW = DATA_WIDTH + CTRL_WIDTH;

    arb_state_e            state_q;
    logic [QW-1:0]         grant_q, last_grant_q, scan_idx, scan_try;
    logic                  seen_body_q, out_wr_q, scan_hit, pop_any;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [CTRL_WIDTH-1:0] out_ctrl_q, sel_ctrl;
    logic [NUM_QUEUES-1:0] overflow_q, overflow_d, empty, full, prog_full, pop;
    logic [WW-1:0]         fifo_dout [NUM_QUEUES];
    logic [FIFO_DEPTH_BITS:0] count_unused [NUM_QUEUES];
    logic [WW-1:0]         sel_word;

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_fifo
        assign pop[g] = pop_any && grant_q == QW'(g);
        arb_in_fifo #(
            .WIDTH(WW),
            .DEPTH_BITS(FIFO_DEPTH_BITS)
        ) u_fifo (
            .clk(clk),
            .reset(reset),
            .din_i({bus.in_ctrl[g*CTRL_WIDTH +: CTRL_WIDTH], bus.in_data[g*DATA_WIDTH +: DATA_WIDTH]}),
            .wr_en_i(bus.in_wr[g]),
            .rd_en_i(pop[g]),
            .dout_o(fifo_dout[g]),
            .count_o(count_unused[g]),
            .empty_o(empty[g]),
            .full_o(full[g]),
            .prog_full_o(prog_full[g])
        );
    end

    assign sel_word   = fifo_dout[grant_q];
    assign sel_ctrl   = sel_word[DATA_WIDTH +: CTRL_WIDTH];
    assign pop_any    = state_q == ARB_XFER && bus.out_rdy && !empty[grant_q];
    assign overflow_d = overflow_q | (bus.in_wr & full & ~pop);

    always_comb begin
        scan_hit = 1'b0;
        scan_idx = '0;
        scan_try = '0;
        // Walk from farthest to nearest so the queue right after last_grant is assigned last and wins.
        for (int k = NUM_QUEUES; k >= 1; k--) begin
            scan_try = QW'((int'(last_grant_q) + k) % NUM_QUEUES);
            if (!empty[scan_try]) begin
                scan_hit = 1'b1;
                scan_idx = scan_try;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            last_grant_q <= QW'(NUM_QUEUES - 1);
            seen_body_q  <= 1'b0;
            out_wr_q     <= 1'b0;
            out_data_q   <= '0;
            out_ctrl_q   <= '0;
            overflow_q   <= '0;
        end else begin
            out_wr_q   <= pop_any;
            overflow_q <= overflow_d;
            if (pop_any) begin
                out_data_q <= sel_word[DATA_WIDTH-1:0];
                out_ctrl_q <= sel_ctrl;
            end
            if (state_q == ARB_IDLE) begin
                if (scan_hit) begin
                    grant_q <= scan_idx;
                    state_q <= ARB_XFER;
                end
            end else if (pop_any) begin
                if (is_body(CTRL_WIDTH_MAX'(sel_ctrl))) begin
                    seen_body_q <= 1'b1;
                end else if (seen_body_q) begin
                    // Non-zero ctrl after body is EOP: release the grant and advance the pointer.
                    seen_body_q  <= 1'b0;
                    last_grant_q <= grant_q;
                    state_q      <= ARB_IDLE;
                end
            end
        end
    end

    assign bus.in_rdy   = ~prog_full;
    assign bus.out_wr   = out_wr_q;
    assign bus.out_data = out_data_q;
    assign bus.out_ctrl = out_ctrl_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_mac_rx_arbiter.sv
// tb_mac_rx_arbiter: directed plus randomized checks of mac_rx_arbiter against a queue-level model
module tb_mac_rx_arbiter;
    localparam int DW = 64;
    localparam int CW = 8;
    localparam int NQ = 4;
    localparam int DEPTH = 8;

    typedef logic [CW+DW-1:0] word_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mac_rx_arbiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_QUEUES(NQ)) bus ();

    mac_rx_arbiter #(
        .DATA_WIDTH(DW),
        .CTRL_WIDTH(CW),
        .NUM_QUEUES(NQ),
        .FIFO_DEPTH_BITS(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    word_t mq [NQ][$];
    word_t gen [NQ][$];
    int owner = -1;
    int last = NQ - 1;
    bit seen = 1'b0;
    logic m_wr = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic [CW-1:0] m_ctrl = '0;
    logic [NQ-1:0] m_ovf = '0;
    logic [NQ-1:0] exp_rdy;

    int log_cyc[$];
    word_t log_w[$];
    word_t w;
    word_t expw[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: per-input queues, a packet owner, and the round-robin pointer.
    always @(posedge clk) begin : model
        word_t wd;
        cyc++;
        if (!reset) begin
            for (int i = 0; i < NQ; i++) mq[i].delete();
            owner = -1;
            last = NQ - 1;
            seen = 1'b0;
            m_wr = 1'b0;
            m_data = '0;
            m_ctrl = '0;
            m_ovf = '0;
        end else begin
            m_wr = 1'b0;
            if (owner < 0) begin
                for (int k = 1; k <= NQ; k++) begin
                    if (mq[(last + k) % NQ].size() > 0) begin
                        owner = (last + k) % NQ;
                        break;
                    end
                end
            end else if (bus.out_rdy && mq[owner].size() > 0) begin
                wd = mq[owner].pop_front();
                m_wr = 1'b1;
                {m_ctrl, m_data} = wd;
                if (m_ctrl == '0) seen = 1'b1;
                else if (seen) begin
                    seen = 1'b0;
                    last = owner;
                    owner = -1;
                end
            end
            for (int i = 0; i < NQ; i++) begin
                if (bus.in_wr[i]) begin
                    if (mq[i].size() < DEPTH) mq[i].push_back({bus.in_ctrl[i*CW +: CW], bus.in_data[i*DW +: DW]});
                    else m_ovf[i] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus.out_wr) begin
            log_cyc.push_back(cyc);
            log_w.push_back({bus.out_ctrl, bus.out_data});
        end
        if (chk_en) begin
            for (int i = 0; i < NQ; i++) exp_rdy[i] = mq[i].size() <= DEPTH - 3;
            chk("out_wr", bus.out_wr, m_wr);
            chk("out_data", bus.out_data, m_data);
            chk("out_ctrl", bus.out_ctrl, m_ctrl);
            chk("in_rdy", bus.in_rdy, exp_rdy);
            chk("overflow", bus.overflow, m_ovf);
        end
    end

    function automatic logic [DW-1:0] mk(input int q, input int n);
        return {8'(q), 56'(n)};
    endfunction

    function automatic logic [7:0] qid(input int k);
        word_t t;
        t = log_w[k];
        return t[63:56];
    endfunction

    function automatic bit model_idle();
        for (int i = 0; i < NQ; i++) if (mq[i].size() > 0) return 1'b0;
        return owner < 0 && !m_wr;
    endfunction

    task automatic tick();
        @(negedge clk);
        bus.in_wr = '0;
    endtask

    task automatic put(input int q, input logic [CW-1:0] c, input logic [DW-1:0] d);
        bus.in_data[q*DW +: DW] = d;
        bus.in_ctrl[q*CW +: CW] = c;
        bus.in_wr[q] = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        bus.out_rdy = 1'b1;
        do begin
            tick();
            n++;
        end while (!model_idle() && n < 300);
        chk("drain_bound", n < 300, 1);
    endtask

    task automatic do_reset();
        bus.in_wr = '0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic make_pkt(input int q);
        int nh, nb;
        nh = $urandom_range(1, 2);
        nb = $urandom_range(1, 6);
        for (int k = 0; k < nh; k++) gen[q].push_back({8'($urandom_range(1, 255)), 8'(q), 56'($urandom)});
        for (int k = 0; k < nb; k++) gen[q].push_back({8'h00, 8'(q), 56'($urandom)});
        gen[q].push_back({8'($urandom_range(1, 255)), 8'(q), 56'($urandom)});
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, s, cnt;
        bit pend;
        bus.in_data = '0;
        bus.in_ctrl = '0;
        bus.in_wr = '0;
        bus.out_rdy = 1'b1;
        // Reset values
        repeat (3) tick();
        chk("rst_out_wr", bus.out_wr, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_ctrl", bus.out_ctrl, 0);
        chk("rst_in_rdy", bus.in_rdy, 4'hF);
        chk("rst_overflow", bus.overflow, 0);
        reset = 1'b1;
        chk_en = 1'b1;

        // Single packet on queue 0
        tick();
        log_cyc.delete();
        log_w.delete();
        t0 = cyc;
        put(0, 8'hFF, mk(0, 100));
        tick();
        put(0, 8'h00, mk(0, 101));
        tick();
        put(0, 8'h08, mk(0, 102));
        drain();
        chk("single_len", log_w.size(), 3);
        if (log_w.size() == 3) begin
            chk("single_latency", log_cyc[0], t0 + 3);
            chk("single_last_cyc", log_cyc[2], t0 + 5);
            chk("single_w0", log_w[0], {8'hFF, mk(0, 100)});
            chk("single_w1", log_w[1], {8'h00, mk(0, 101)});
            chk("single_w2", log_w[2], {8'h08, mk(0, 102)});
        end

        // Round robin from a fresh pointer
        do_reset();
        log_cyc.delete();
        log_w.delete();
        for (int k = 0; k < 4; k++) begin
            for (int q = 0; q < 3; q++) put(q, k == 0 ? 8'hFF : (k == 3 ? 8'h04 : 8'h00), mk(q, k));
            tick();
        end
        drain();
        chk("rr_len", log_w.size(), 12);
        if (log_w.size() == 12) begin
            chk("rr_first_q0", qid(0), 0);
            chk("rr_second_q1", qid(4), 1);
            chk("rr_third_q2", qid(8), 2);
            chk("rr_bubble", log_cyc[4] - log_cyc[3], 2);
            chk("rr_span", log_cyc[11] - log_cyc[0], 13);
        end
        log_cyc.delete();
        log_w.delete();
        for (int k = 0; k < 4; k++) begin
            put(2, k == 0 ? 8'hFF : (k == 3 ? 8'h04 : 8'h00), mk(2, 10 + k));
            put(0, k == 0 ? 8'hFF : (k == 3 ? 8'h04 : 8'h00), mk(0, 10 + k));
            tick();
        end
        drain();
        chk("rr2_len", log_w.size(), 8);
        if (log_w.size() == 8) begin
            chk("rr2_first_q0", qid(0), 0);
            chk("rr2_second_q2", qid(4), 2);
        end

        // No interleave: queue 1 stalls mid-packet while queue 2 waits with a full packet
        log_cyc.delete();
        log_w.delete();
        put(1, 8'hFF, mk(1, 0)); put(2, 8'hFF, mk(2, 0)); tick();
        put(1, 8'h00, mk(1, 1)); put(2, 8'h00, mk(2, 1)); tick();
        put(1, 8'h00, mk(1, 2)); put(2, 8'h00, mk(2, 2)); tick();
        put(2, 8'h04, mk(2, 3)); tick();
        repeat (5) tick();
        put(1, 8'h00, mk(1, 3)); tick();
        put(1, 8'h02, mk(1, 4));
        drain();
        chk("nointlv_len", log_w.size(), 9);
        if (log_w.size() == 9) begin
            chk("nointlv_q1_eop", log_w[4], {8'h02, mk(1, 4)});
            chk("nointlv_q2_after", qid(5), 2);
            chk("nointlv_gap", log_cyc[5] - log_cyc[4], 2);
        end

        // Backpressure mid-packet
        log_cyc.delete();
        log_w.delete();
        expw.delete();
        for (int k = 0; k < 8; k++) begin
            w = {k == 0 ? 8'hFF : (k == 7 ? 8'h10 : 8'h00), mk(0, 20 + k)};
            expw.push_back(w);
            tick();
            put(0, w[DW +: CW], w[DW-1:0]);
        end
        tick();
        s = cyc;
        bus.out_rdy = 1'b0;
        repeat (4) tick();
        bus.out_rdy = 1'b1;
        drain();
        cnt = 0;
        foreach (log_cyc[k]) if (log_cyc[k] >= s + 2 && log_cyc[k] <= s + 4) cnt++;
        chk("bp_stall_quiet", cnt, 0);
        chk("bp_len", log_w.size(), 8);
        if (log_w.size() == 8) foreach (expw[k]) chk("bp_word", log_w[k], expw[k]);

        // Overflow on queue 3
        log_cyc.delete();
        log_w.delete();
        bus.out_rdy = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            put(3, k == 1 ? 8'hFF : (k == 8 ? 8'h01 : 8'h00), mk(3, 30 + k));
            tick();
            if (k == 5) chk("ovf_rdy_after5", bus.in_rdy[3], 1);
            if (k == 6) chk("ovf_rdy_after6", bus.in_rdy[3], 0);
            if (k == 8) chk("ovf_clear_after8", bus.overflow[3], 0);
            if (k == 9) chk("ovf_set_after9", bus.overflow[3], 1);
        end
        drain();
        chk("ovf_len", log_w.size(), 8);
        chk("ovf_sticky", bus.overflow[3], 1);

        // Reset mid-packet
        for (int k = 0; k < 6; k++) begin
            put(2, k == 0 ? 8'hFF : (k == 5 ? 8'h03 : 8'h00), mk(2, 40 + k));
            tick();
        end
        chk("rstmid_in_xfer", bus.out_wr, 1);
        reset = 1'b0;
        tick();
        chk("rstmid_out_wr", bus.out_wr, 0);
        chk("rstmid_in_rdy", bus.in_rdy, 4'hF);
        chk("rstmid_overflow", bus.overflow, 0);
        reset = 1'b1;
        log_cyc.delete();
        log_w.delete();
        for (int k = 0; k < 3; k++) begin
            put(1, k == 0 ? 8'hFF : (k == 2 ? 8'h08 : 8'h00), mk(1, 50 + k));
            put(0, k == 0 ? 8'hFF : (k == 2 ? 8'h08 : 8'h00), mk(0, 50 + k));
            tick();
        end
        drain();
        chk("rstmid_len", log_w.size(), 6);
        if (log_w.size() == 6) chk("rstmid_q0_first", qid(0), 0);

        // Randomized traffic with random backpressure
        for (int c = 0; c < 3000; c++) begin
            bus.out_rdy = $urandom_range(0, 3) != 0;
            for (int i = 0; i < NQ; i++) begin
                if (gen[i].size() == 0 && c < 2500) make_pkt(i);
                if (gen[i].size() > 0 && bus.in_rdy[i] && $urandom_range(0, 1) == 1) begin
                    w = gen[i].pop_front();
                    put(i, w[DW +: CW], w[DW-1:0]);
                end
            end
            tick();
        end
        bus.out_rdy = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            pend = 1'b0;
            for (int i = 0; i < NQ; i++) begin
                if (gen[i].size() > 0) begin
                    pend = 1'b1;
                    if (bus.in_rdy[i]) begin
                        w = gen[i].pop_front();
                        put(i, w[DW +: CW], w[DW-1:0]);
                    end
                end
            end
            if (!pend) break;
            tick();
        end
        chk("rand_gen_done", pend, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mac_rx_arbiter.md
# mac_rx_arbiter

Merges the receive streams of several MAC groups into the single 64-bit user datapath. It sits directly downstream of the MAC groups' `out_data`/`out_ctrl`/`out_wr`/`out_rdy` ports and upstream of the first packet-processing stage. Each input has its own small elastic FIFO. A packet-granular round-robin arbiter drains the FIFOs, so packets from different MACs are never interleaved on the output.

## Interface
- `DATA_WIDTH`, 64: datapath word width.
- `CTRL_WIDTH`, `DATA_WIDTH/8`: control width per word.
- `NUM_QUEUES`, 4: number of MAC inputs (2..8).
- `FIFO_DEPTH_BITS`, 3: log2 of per-input FIFO depth (8 words).

Ports:
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-low (0 = reset, sampled on `clk` rising edge).
- `in_data`  in  `NUM_QUEUES*DATA_WIDTH`  input words; queue i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `in_ctrl`  in  `NUM_QUEUES*CTRL_WIDTH`  input ctrl, same packing as `in_data`.
- `in_wr`  in  `NUM_QUEUES`  per-queue write strobe.
- `in_rdy`  out  `NUM_QUEUES`  per-queue ready (almost-not-full).
- `out_data`  out  `DATA_WIDTH`  merged output word.
- `out_ctrl`  out  `CTRL_WIDTH`  merged output ctrl.
- `out_wr`  out  1  output write strobe.
- `out_rdy`  in  1  downstream ready.
- `overflow`  out  `NUM_QUEUES`  sticky per-queue flag: a write arrived while that FIFO was full.

## Operation
- Packet framing: packet = one or more header words (ctrl≠0), then body words (ctrl=0). The first ctrl≠0 word after at least one ctrl=0 word is the last word (EOP). Packets with no ctrl=0 word are malformed; behaviour is undefined.
- Input FIFO i:
  - Push on `in_wr[i]` when not full.
  - `in_rdy[i]` = (count ≤ DEPTH−3). This leaves 2 words of slack for upstream write-ahead.
  - A push while full is dropped and sets `overflow[i]`. `overflow[i]` clears only on reset.
- Arbiter FSM:
  - **IDLE**:
    - Scan queues starting at `last_grant+1` (mod `NUM_QUEUES`).
    - Grant the first non-empty queue and go to XFER. No word is popped this cycle.
    - If all queues are empty, stay in IDLE.
  - **XFER**:
    - Each cycle where `out_rdy`=1 and the granted FIFO is non-empty, pop one word into the output register.
    - `seen_body` sets on popping a ctrl=0 word.
    - Popping a ctrl≠0 word with `seen_body`=1 is EOP:
      - `last_grant` ← grant.
      - `seen_body` ← 0.
      - Next state IDLE.
    - If the granted FIFO runs empty mid-packet, hold in XFER with grant fixed. Other queues are never serviced mid-packet.
- Simultaneous push and pop on the same FIFO in one cycle: both happen, and count is unchanged. This is legal even when the FIFO is full, because the pop frees the slot.
- Reset (`reset`=0) outputs:
  - FIFOs emptied.
  - FSM → IDLE.
  - `last_grant` ← `NUM_QUEUES−1`, so queue 0 wins first.
  - `out_wr`=0, `out_data`=0, `out_ctrl`=0.
  - `overflow`=0, `in_rdy`=all 1s.
  - A reset mid-packet discards the partial packet. No EOP is emitted.

## Timing
- Output is registered:
  - `out_wr` is asserted the cycle after a pop.
  - `out_data`/`out_ctrl` are valid only while `out_wr`=1, and hold their last value otherwise.
- Latency: a word written to an empty FIFO of an idle arbiter appears on the output 3 cycles after the `in_wr` edge:
  - cycle 1: FIFO write;
  - cycle 2: IDLE grant;
  - cycle 3: pop → `out_wr`.
- Throughput: 1 word/cycle within a packet. There is a 1-cycle bubble (the IDLE state) between packets.
- `out_rdy` is sampled in the pop cycle. The downstream must accept one more word after deasserting `out_rdy`.
- FIFO count and `in_rdy` update the cycle after the push/pop edge.

## Structure
- Shared package/defines:
  - `NUM_QUEUES` bounds;
  - FSM state encoding (`ARB_IDLE`, `ARB_XFER`);
  - the rule that ctrl=0 marks a body word.
- Sub-module `arb_in_fifo`:
  - synchronous single-clock FIFO, width `DATA_WIDTH+CTRL_WIDTH`;
  - outputs: `count`, `empty`, `full`, `prog_full`, and a first-word-fall-through `dout`.
- Instantiate `NUM_QUEUES` copies with a generate loop. The top level holds the FSM, the round-robin pointer, the output register and the `overflow` flags.

## Test plan
- Single packet: queue 0 gets 3 words (ctrl 0xFF, 0x00, 0x08). Output is the same 3 words on consecutive cycles, first `out_wr` 3 cycles after the first `in_wr`, then return to IDLE.
- Round-robin: queues 0, 1, 2 each get one 4-word packet in the same cycle. Output order is 0, 1, 2, with exactly one idle cycle between packets. A second round with queues 2 and 0 loaded starts at queue 0.
- No interleave: queue 1 stalls mid-packet for 5 cycles while queue 2 holds a full packet. Queue 2's first word appears only after queue 1's EOP.
- Backpressure: `out_rdy`=0 for 4 cycles mid-packet. No pops during the stall, at most one trailing word after deassertion, and the packet is otherwise intact.
- Overflow: 9 consecutive writes to queue 3 with `out_rdy`=0. `in_rdy[3]` drops after the 6th write, the 9th write is dropped, and `overflow[3]`=1 persists until reset.
- Reset mid-packet: `reset`=0 during XFER. The next cycle has `out_wr`=0, all FIFOs empty and `in_rdy` all 1s, and queue 0 is granted first afterwards.
